// File: rtl/tune_detector_if.sv
// Tone-path bundle between the pin mux/mode source and the tune detector.
// master drives the wave and the mode bit; slave returns the decoded tune.
interface tune_detector_if;
  logic       wave_in;
  logic       mode;
  logic [3:0] tune;
  logic       tune_valid;
  logic       tune_strobe;

  modport master (output wave_in, output mode,
                  input  tune, input tune_valid, input tune_strobe);
  modport slave  (input  wave_in, input mode,
                  output tune, output tune_valid, output tune_strobe);
endinterface

// File: rtl/tune_detector.sv
// tune_detector: measures the period of the incoming square wave and maps it
// back to the 4-bit tune code (0..8) of the A=432 Hz Pythagorean table.
// Nominal period = BASE_DIV * N, BASE_DIV = C_BASE_DIV (mode 0) or F_BASE_DIV
// (mode 1). All nominals are elaboration-time constants.
// Optional feature: define DUTY_CHECK_EN to reject periods whose high time is
// outside 50% +/- 12.5% of the period.
module tune_detector #(
  parameter int unsigned C_BASE_DIV = 96,
  parameter int unsigned F_BASE_DIV = 72,
  parameter int unsigned TOL_SHIFT  = 6,
  parameter int unsigned STABLE_CNT = 2,
  parameter int unsigned TIMEOUT    = 131071
) (
  input  logic           clk12M,
  input  logic           Rst,
  tune_detector_if.slave bus
);

  localparam int MW = $clog2(STABLE_CNT + 1);
  localparam int unsigned NTAB [9] = '{648, 576, 512, 486, 432, 384, 324, 288, 243};

  logic          sync1_q, sync2_q, sync3_q;
  logic          mode_q;
  logic [16:0]   cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic [17:0]   period_q, period_d;
  logic          per_vld_q, per_vld_d;
  logic          cls_vld_q, cls_hit_q;
  logic [3:0]    cls_code_q;
  logic [MW-1:0] match_q, match_d;
  logic [3:0]    last_code_q, last_code_d;
  logic [3:0]    tune_q, tune_d;
  logic          valid_q, valid_d;
  logic          strobe_q, strobe_d;

  logic          edge_w, mode_chg_w, timeout_w;
  logic          hit_w, duty_ok_w;
  logic [3:0]    code_w;
  logic [17:0]   nom_w, tol_w, diff_w;

  assign edge_w     = sync2_q & ~sync3_q;
  assign mode_chg_w = (bus.mode != mode_q);
  assign timeout_w  = (cnt_q == 17'(TIMEOUT)) && !edge_w;

  // Two-flop synchronizer, edge history flop and previous mode for change detect
  always_ff @(posedge clk12M or posedge Rst) begin
    if (Rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      sync1_q <= bus.wave_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      mode_q  <= bus.mode;
    end
  end

  // Period counter: restart on each edge, saturate at TIMEOUT; first edge only arms
  always_comb begin
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    period_d  = period_q;
    per_vld_d = 1'b0;
    if (edge_w) begin
      cnt_d = '0;
      if (armed_q && !mode_chg_w) begin
        period_d  = {1'b0, cnt_q} + 18'd1;
        per_vld_d = 1'b1;
      end
      armed_d = 1'b1;
    end else begin
      if (cnt_q != 17'(TIMEOUT)) cnt_d = cnt_q + 17'd1;
      if (timeout_w) armed_d = 1'b0;
    end
    if (mode_chg_w) armed_d = 1'b0;
  end

  // Measurement state registers
  always_ff @(posedge clk12M or posedge Rst) begin
    if (Rst) begin
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      period_q  <= '0;
      per_vld_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      period_q  <= period_d;
      per_vld_q <= per_vld_d;
    end
  end

  // Scan the table of the current mode; first code inside its window wins
  always_comb begin
    hit_w  = 1'b0;
    code_w = '0;
    nom_w  = '0;
    tol_w  = '0;
    diff_w = '0;
    for (int i = 0; i < 9; i++) begin
      nom_w  = bus.mode ? 18'(F_BASE_DIV * NTAB[i]) : 18'(C_BASE_DIV * NTAB[i]);
      tol_w  = nom_w >> TOL_SHIFT;
      diff_w = (period_q > nom_w) ? (period_q - nom_w) : (nom_w - period_q);
      if (!hit_w && (diff_w <= tol_w)) begin
        hit_w  = 1'b1;
        code_w = 4'(i);
      end
    end
  end

`ifdef DUTY_CHECK_EN
  logic [16:0] hi_cnt_q, high_q;
  logic [17:0] twice_hi_w, duty_diff_w;

  // High-time counter; the edge cycle itself counts as the first high cycle
  always_ff @(posedge clk12M or posedge Rst) begin
    if (Rst) begin
      hi_cnt_q <= '0;
      high_q   <= '0;
    end else if (edge_w) begin
      high_q   <= hi_cnt_q;
      hi_cnt_q <= 17'd1;
    end else if (sync2_q && (hi_cnt_q != '1)) begin
      hi_cnt_q <= hi_cnt_q + 17'd1;
    end
  end

  assign twice_hi_w  = {high_q, 1'b0};
  assign duty_diff_w = (twice_hi_w > period_q) ? (twice_hi_w - period_q) : (period_q - twice_hi_w);
  assign duty_ok_w   = (duty_diff_w <= (period_q >> 2));
`else
  assign duty_ok_w = 1'b1;
`endif

  // Classification result, registered one cycle after the period latches
  always_ff @(posedge clk12M or posedge Rst) begin
    if (Rst) begin
      cls_vld_q  <= 1'b0;
      cls_hit_q  <= 1'b0;
      cls_code_q <= '0;
    end else begin
      cls_vld_q  <= per_vld_q & ~mode_chg_w;
      cls_hit_q  <= hit_w & duty_ok_w;
      cls_code_q <= code_w;
    end
  end

  // Match history and output update; strobe only on a new or changed note
  always_comb begin
    match_d     = match_q;
    last_code_d = last_code_q;
    tune_d      = tune_q;
    valid_d     = valid_q;
    strobe_d    = 1'b0;
    if (mode_chg_w || timeout_w) begin
      match_d = '0;
      if (timeout_w) valid_d = 1'b0;
    end else if (cls_vld_q) begin
      if (!cls_hit_q) begin
        match_d = '0;
      end else begin
        if ((match_q != '0) && (cls_code_q == last_code_q)) begin
          if (match_q != MW'(STABLE_CNT)) match_d = match_q + MW'(1);
        end else begin
          match_d = MW'(1);
        end
        last_code_d = cls_code_q;
        if (match_d == MW'(STABLE_CNT)) begin
          tune_d   = cls_code_q;
          valid_d  = 1'b1;
          strobe_d = !valid_q || (cls_code_q != tune_q);
        end
      end
    end
  end

  // History and output registers
  always_ff @(posedge clk12M or posedge Rst) begin
    if (Rst) begin
      match_q     <= '0;
      last_code_q <= '0;
      tune_q      <= '0;
      valid_q     <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      match_q     <= match_d;
      last_code_q <= last_code_d;
      tune_q      <= tune_d;
      valid_q     <= valid_d;
      strobe_q    <= strobe_d;
    end
  end

  assign bus.tune        = tune_q;
  assign bus.tune_valid  = valid_q;
  assign bus.tune_strobe = strobe_q;

endmodule

// File: tb/tb_tune_detector.sv
// Bench for tune_detector. Base dividers and timeout are scaled down by 24
// (C 4, F 3, timeout 5461) so every table period keeps its ratio while the
// run stays short. Expected outputs come from an event-level model driven by
// the rising-edge times the bench itself produces.
module tb_tune_detector;

  localparam int C_DIV  = 4;
  localparam int F_DIV  = 3;
  localparam int TOL    = 6;
  localparam int STABLE = 2;
  localparam int TMO    = 5461;
`ifdef DUTY_CHECK_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic clk12M = 1'b0;
  logic Rst    = 1'b0;

  tune_detector_if bus ();

  tune_detector #(
    .C_BASE_DIV (C_DIV),
    .F_BASE_DIV (F_DIV),
    .TOL_SHIFT  (TOL),
    .STABLE_CNT (STABLE),
    .TIMEOUT    (TMO)
  ) dut (
    .clk12M (clk12M),
    .Rst    (Rst),
    .bus    (bus)
  );

  // 12 MHz stand-in clock
  always #5 clk12M = ~clk12M;

  // Free-running cycle index
  int cyc = 0;
  always @(posedge clk12M) cyc <= cyc + 1;

  // Strobe monitor, sampled away from the active edge
  int strobeCount   = 0;
  int lastStrobeCyc = -1;
  always @(negedge clk12M) begin
    if (bus.tune_strobe === 1'b1) begin
      strobeCount   <= strobeCount + 1;
      lastStrobeCyc <= cyc;
    end
  end

  int nAsserts  = 0;
  int nFailures = 0;

  // Reference model state
  int nTab [9] = '{648, 576, 512, 486, 432, 384, 324, 288, 243};
  int mMode, mTune, mValid, mArmed, mMatch, mLast;
  int lastRise, prevHigh;
  int expStrobes   = 0;
  int expStrobeCyc = -1;

  function automatic int classify(input int p, input int h);
    int d;
    int nom;
    int diff;
    d = 2 * h - p;
    if (d < 0) d = -d;
    if (DUTY && (d > p / 4)) return -1;
    for (int c = 0; c < 9; c++) begin
      nom  = (mMode != 0 ? F_DIV : C_DIV) * nTab[c];
      diff = p - nom;
      if (diff < 0) diff = -diff;
      if (diff <= (nom >> TOL)) return c;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mTune    = 0;
    mValid   = 0;
    mArmed   = 0;
    mMatch   = 0;
    mLast    = 0;
    lastRise = cyc - 3;
  endtask

  task automatic modelSync(input int now);
    if (now >= lastRise + TMO + 4) begin
      mValid = 0;
      mArmed = 0;
      mMatch = 0;
    end
  endtask

  task automatic modelRise(input int c);
    int code;
    if (c - lastRise > TMO + 1) begin
      mValid = 0;
      mArmed = 0;
      mMatch = 0;
    end
    if (mArmed == 0) begin
      mArmed = 1;
    end else begin
      code = classify(c - lastRise, prevHigh);
      if (code < 0) begin
        mMatch = 0;
      end else begin
        if (mMatch > 0 && code == mLast) mMatch = (mMatch + 1 > STABLE) ? STABLE : mMatch + 1;
        else mMatch = 1;
        mLast = code;
        if (mMatch == STABLE) begin
          if (mValid == 0 || code != mTune) begin
            expStrobes++;
            expStrobeCyc = c + 5;
          end
          mTune  = code;
          mValid = 1;
        end
      end
    end
    lastRise = c;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFailures++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    modelSync(cyc);
    checkOutput({tag, "_tune"},    32'(bus.tune),       32'(mTune));
    checkOutput({tag, "_valid"},   32'(bus.tune_valid), 32'(mValid));
    checkOutput({tag, "_strobes"}, 32'(strobeCount),    32'(expStrobes));
    checkOutput({tag, "_strbcyc"}, 32'(lastStrobeCyc),  32'(expStrobeCyc));
  endtask

  // One full wave period starting with a rising edge at the current negedge
  task automatic applyStimulus(input int p, input int h);
    bus.wave_in = 1'b1;
    modelRise(cyc);
    prevHigh = h;
    repeat (h) @(negedge clk12M);
    bus.wave_in = 1'b0;
    repeat (p - h) @(negedge clk12M);
  endtask

  task automatic setMode(input int m);
    if (m != mMode) begin
      mArmed = 0;
      mMatch = 0;
    end
    mMode    = m;
    bus.mode = m[0];
  endtask

  task automatic resetPulse();
    Rst = 1'b1;
    repeat (2) @(negedge clk12M);
    Rst = 1'b0;
    modelReset();
  endtask

  initial begin
    int target;
    int code;
    int nom;
    int tol;
    int p;

    bus.wave_in = 1'b0;
    bus.mode    = 1'b0;
    mMode       = 0;
    prevHigh    = 0;
    #1 Rst = 1'b1;
    repeat (3) @(negedge clk12M);
    modelReset();
    checkAll("reset");
    checkOutput("reset_strobe", 32'(bus.tune_strobe), 32'd0);
    Rst = 1'b0;
    modelReset();
    repeat (4) @(negedge clk12M);

    // T1: C-major code 4, four periods, single strobe after third rise
    setMode(0);
    repeat (4) applyStimulus(1728, 864);
    checkAll("t1");
    checkOutput("t1_tune_const", 32'(bus.tune), 32'd4);
    checkOutput("t1_strobes_const", 32'(strobeCount), 32'd1);

    // T2: F-major high C, then code 7
    setMode(1);
    repeat (3) applyStimulus(729, 364);
    checkAll("t2a");
    checkOutput("t2a_tune_const", 32'(bus.tune), 32'd8);
    repeat (3) applyStimulus(864, 432);
    checkAll("t2b");
    checkOutput("t2b_tune_const", 32'(bus.tune), 32'd7);
    checkOutput("t2b_strobes_const", 32'(strobeCount), 32'd3);

    // T3: code 6 in C-major, flip mode, same wave decodes as F-major code 4
    setMode(0);
    repeat (3) applyStimulus(1296, 648);
    checkAll("t3a");
    checkOutput("t3a_tune_const", 32'(bus.tune), 32'd6);
    setMode(1);
    repeat (2) applyStimulus(1296, 648);
    checkAll("t3_hold");
    applyStimulus(1296, 648);
    checkAll("t3b");
    checkOutput("t3b_tune_const", 32'(bus.tune), 32'd4);

    // T4: period between windows after reset never matches
    setMode(0);
    resetPulse();
    repeat (3) applyStimulus(1875, 937);
    checkAll("t4");
    checkOutput("t4_valid_const", 32'(bus.tune_valid), 32'd0);

    // T5: qualify, then silence up to and past the timeout boundary
    repeat (3) applyStimulus(1728, 864);
    checkAll("t5_note");
    target = lastRise + TMO + 3;
    while (cyc < target) @(negedge clk12M);
    checkAll("t5_before");
    checkOutput("t5_before_const", 32'(bus.tune_valid), 32'd1);
    @(negedge clk12M);
    checkAll("t5_after");
    checkOutput("t5_after_const", 32'(bus.tune_valid), 32'd0);
    repeat (10) @(negedge clk12M);
    repeat (2) applyStimulus(1296, 648);
    checkAll("t5_arming");
    applyStimulus(1296, 648);
    checkAll("t5_requal");
    checkOutput("t5_requal_const", 32'(bus.tune), 32'd6);

    // Window edges: nominal+tol matches, nominal+tol+1 does not
    repeat (3) applyStimulus(1755, 877);
    checkAll("win_in");
    repeat (3) applyStimulus(1756, 878);
    checkAll("win_out");

    // Asynchronous reset in the middle of a high phase
    bus.wave_in = 1'b1;
    modelRise(cyc);
    repeat (100) @(negedge clk12M);
    #2 Rst = 1'b1;
    #1;
    checkOutput("areset_tune", 32'(bus.tune), 32'd0);
    checkOutput("areset_valid", 32'(bus.tune_valid), 32'd0);
    checkOutput("areset_strobe", 32'(bus.tune_strobe), 32'd0);
    bus.wave_in = 1'b0;
    repeat (3) @(negedge clk12M);
    Rst = 1'b0;
    modelReset();
    checkAll("areset_after");

    // Randomized tones, jitter and duty
    for (int k = 0; k < 3; k++) begin
      setMode(int'($urandom_range(0, 1)));
      code = int'($urandom_range(0, 8));
      nom  = (mMode != 0 ? F_DIV : C_DIV) * nTab[code];
      tol  = nom >> TOL;
      for (int j = 0; j < 3; j++) begin
        if ($urandom_range(0, 3) == 0) p = int'($urandom_range(700, 2700));
        else p = nom - tol / 2 + int'($urandom_range(0, tol));
        applyStimulus(p, p * int'($urandom_range(30, 70)) / 100);
      end
      checkAll($sformatf("rand%0d", k));
    end

`ifdef DUTY_CHECK_EN
    // T6: 25% duty never qualifies, 50% duty does
    setMode(0);
    resetPulse();
    repeat (4) applyStimulus(1728, 432);
    checkAll("t6_quarter");
    checkOutput("t6_quarter_const", 32'(bus.tune_valid), 32'd0);
    repeat (3) applyStimulus(1728, 864);
    checkAll("t6_half");
    checkOutput("t6_half_const", 32'(bus.tune), 32'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFailures);
    $finish;
  end

endmodule
